hpm_sample_ctrl: RTL and testbench



---
 rtl/hpm_sample_ctrl_pkg.sv | 20 ++
 rtl/hpm_mask_scan.sv | 26 ++
 rtl/hpm_sample_ctrl.sv | 151 +++++++++++++++
 tb/tb_hpm_sample_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpm_sample_ctrl_pkg.sv
// Shared types and constants for the HPM periodic sampling controller.
package hpm_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    SMP_IDLE,
    SMP_READ,
    SMP_CLEAR,
    SMP_HOLD
  } hpm_smp_state_t;

  localparam int unsigned HPM_FIRST_IDX      = 3;
  localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;

  function automatic logic [31:3] idx_onehot(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd1 << idx;
    return v[31:3];
  endfunction

endpackage

// File: rtl/hpm_mask_scan.sv
// Finds the lowest set counter index in a [31:3] mask; flags empty and single-bit masks.
module hpm_mask_scan
  import hpm_sample_ctrl_pkg::*;
(
  input  logic [31:3] mask,
  output logic [4:0]  idx,
  output logic        found,
  output logic        is_last
);

  logic [31:0] full;

  always_comb begin
    full  = {mask, 3'b000};
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 31; i >= HPM_FIRST_IDX; i--) begin
      if (full[i]) begin
        idx   = 5'(i);
        found = 1'b1;
      end
    end
    is_last = found && ((full & (full - 32'd1)) == '0);
  end

endmodule

// File: rtl/hpm_sample_ctrl.sv
// Periodic/manual sampler for the HPM counter file; core CSR traffic always wins the shared port.
module hpm_sample_ctrl
  import hpm_sample_ctrl_pkg::*;
#(
  parameter int CSR_ADDR_WIDTH   = 12,
  parameter int XLEN             = 64,
  parameter int HPM_NUM_COUNTERS = 29,
  parameter int PERIOD_WIDTH     = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cfg_en_i,
  input  logic [PERIOD_WIDTH-1:0]   cfg_period_i,
  input  logic [31:3]               cfg_mask_i,
  input  logic                      cfg_clear_i,
  input  logic                      trigger_i,
  input  logic                      ovr_clr_i,
  input  logic                      core_req_i,
  input  logic [CSR_ADDR_WIDTH-1:0] core_addr_i,
  input  logic                      core_we_i,
  input  logic [XLEN-1:0]           core_data_i,
  output logic [XLEN-1:0]           core_data_o,
  output logic [CSR_ADDR_WIDTH-1:0] hpm_addr_o,
  output logic                      hpm_we_o,
  output logic [XLEN-1:0]           hpm_data_o,
  input  logic [XLEN-1:0]           hpm_data_i,
  output logic                      smp_valid_o,
  input  logic                      smp_ready_i,
  output logic [4:0]                smp_idx_o,
  output logic [XLEN-1:0]           smp_data_o,
  output logic                      smp_last_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  hpm_smp_state_t            state_q, state_d;
  logic [31:3]               mask_q, mask_d, impl_mask, cfg_sel, scan_in;
  logic                      clear_q, clear_d;
  logic [XLEN-1:0]           sample_q;
  logic                      capture;
  logic [PERIOD_WIDTH-1:0]   timer_q;
  logic                      timer_run, timer_fire, trig;
  logic                      overrun_q;
  logic [4:0]                cur_idx;
  logic                      scan_found, scan_last;
  logic [CSR_ADDR_WIDTH-1:0] counter_addr, scan_addr;
  logic                      scan_we;

  always_comb begin
    impl_mask = '0;
    for (int unsigned i = HPM_FIRST_IDX; i <= 31; i++)
      impl_mask[i] = (int'(i) <= HPM_NUM_COUNTERS + 2);
  end

  assign cfg_sel = cfg_mask_i & impl_mask;

  // While scanning, mask_q keeps the current index set, so its lowest bit is the
  // active counter and a single remaining bit marks the last record.
  assign scan_in = (state_q == SMP_IDLE) ? cfg_sel : mask_q;

  hpm_mask_scan u_scan (
    .mask    (scan_in),
    .idx     (cur_idx),
    .found   (scan_found),
    .is_last (scan_last)
  );

  assign counter_addr = CSR_ADDR_WIDTH'(CSR_MHPM_COUNTER_3) + CSR_ADDR_WIDTH'(cur_idx)
                      - CSR_ADDR_WIDTH'(HPM_FIRST_IDX);

  assign timer_run  = cfg_en_i && (cfg_period_i != '0);
  assign timer_fire = timer_run && (timer_q <= PERIOD_WIDTH'(1));
  assign trig       = timer_fire || trigger_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                      timer_q <= '0;
    else if (!timer_run || timer_fire) timer_q <= cfg_period_i;
    else                              timer_q <= timer_q - PERIOD_WIDTH'(1);
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    clear_d   = clear_q;
    capture   = 1'b0;
    scan_addr = '0;
    scan_we   = 1'b0;
    case (state_q)
      SMP_IDLE: begin
        if (trig) begin
          mask_d  = cfg_sel;
          clear_d = cfg_clear_i;
          if (scan_found) state_d = SMP_READ;
        end
      end
      SMP_READ: begin
        if (!core_req_i) begin
          scan_addr = counter_addr;
          capture   = 1'b1;
          state_d   = clear_q ? SMP_CLEAR : SMP_HOLD;
        end
      end
      SMP_CLEAR: begin
        if (core_req_i) begin
          if (core_we_i && (core_addr_i == counter_addr)) state_d = SMP_HOLD;
        end else begin
          scan_addr = counter_addr;
          scan_we   = 1'b1;
          state_d   = SMP_HOLD;
        end
      end
      SMP_HOLD: begin
        if (smp_ready_i) begin
          mask_d  = mask_q & ~idx_onehot(cur_idx);
          state_d = scan_last ? SMP_IDLE : SMP_READ;
        end
      end
      default: state_d = SMP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= SMP_IDLE;
      mask_q    <= '0;
      clear_q   <= 1'b0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      clear_q <= clear_d;
      if (capture) sample_q <= hpm_data_i;
      if (ovr_clr_i)                           overrun_q <= 1'b0;
      else if (trig && (state_q != SMP_IDLE))  overrun_q <= 1'b1;
    end
  end

  assign hpm_addr_o  = core_req_i ? core_addr_i : scan_addr;
  assign hpm_we_o    = core_req_i ? core_we_i   : scan_we;
  assign hpm_data_o  = core_req_i ? core_data_i : '0;
  assign core_data_o = core_req_i ? hpm_data_i  : '0;

  assign smp_valid_o = (state_q == SMP_HOLD);
  assign smp_idx_o   = smp_valid_o ? cur_idx : '0;
  assign smp_last_o  = smp_valid_o && scan_last;
  assign smp_data_o  = sample_q;
  assign busy_o      = (state_q != SMP_IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Directed + randomized bench for hpm_sample_ctrl with a behavioural counter file and record model.
module tb_hpm_sample_ctrl;

  localparam logic [11:0] CTR_BASE = 12'hB03;

  logic        clk, rstn;
  logic        cfg_en, cfg_clear, trigger, ovr_clr;
  logic [31:0] cfg_period;
  logic [31:3] cfg_mask;
  logic        core_req, core_we;
  logic [11:0] core_addr;
  logic [63:0] core_wdata, core_rdata;
  logic [11:0] hpm_addr;
  logic        hpm_we;
  logic [63:0] hpm_wdata, hpm_rdata;
  logic        smp_valid, smp_ready, smp_last, busy, overrun;
  logic [4:0]  smp_idx;
  logic [63:0] smp_data;

  hpm_sample_ctrl #(
    .CSR_ADDR_WIDTH(12), .XLEN(64), .HPM_NUM_COUNTERS(29), .PERIOD_WIDTH(32)
  ) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cfg_en_i(cfg_en), .cfg_period_i(cfg_period), .cfg_mask_i(cfg_mask),
    .cfg_clear_i(cfg_clear), .trigger_i(trigger), .ovr_clr_i(ovr_clr),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_we_i(core_we),
    .core_data_i(core_wdata), .core_data_o(core_rdata),
    .hpm_addr_o(hpm_addr), .hpm_we_o(hpm_we), .hpm_data_o(hpm_wdata), .hpm_data_i(hpm_rdata),
    .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_idx_o(smp_idx),
    .smp_data_o(smp_data), .smp_last_o(smp_last),
    .busy_o(busy), .overrun_o(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter file model: combinational read, write on clock edge.
  logic [63:0] ctr [3:31] = '{default: '0};
  logic        ctr_hit;
  int          ctr_sel;

  always_comb begin
    ctr_hit   = (hpm_addr >= CTR_BASE) && (hpm_addr <= CTR_BASE + 12'd28);
    ctr_sel   = ctr_hit ? int'(hpm_addr - CTR_BASE) + 3 : 3;
    hpm_rdata = ctr_hit ? ctr[ctr_sel] : '0;
  end

  always @(posedge clk) if (hpm_we && ctr_hit) ctr[ctr_sel] <= hpm_wdata;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void build_exp(input logic [31:3] m);
    rec_t r;
    exp_q.delete();
    for (int i = 3; i <= 31; i++) begin
      if (m[i]) begin
        r.idx = 5'(i); r.data = ctr[i]; r.last = 1'b0;
        exp_q.push_back(r);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  task automatic core_write(input int idx, input logic [63:0] d);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = CTR_BASE + 12'(idx - 3); core_wdata = d;
    @(posedge clk); #1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic run_scan(input logic [31:3] m, input bit clr, input bit rdy_rand, input string tag);
    int n, first_k, last_k, we_cnt, got;
    bit stalled;
    rec_t held, r;
    logic [63:0] snap [3:31];
    build_exp(m);
    n = exp_q.size();
    snap = ctr;
    @(posedge clk); #1;
    cfg_mask = m; cfg_clear = clr; trigger = 1'b1; smp_ready = 1'b1;
    first_k = -1; last_k = -1; we_cnt = 0; got = 0; stalled = 1'b0;
    for (int k = 1; k <= 300 && got < n; k++) begin
      @(posedge clk); #1;
      trigger = 1'b0;
      smp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rdy_rand) begin
        cfg_mask = 29'($urandom);
        cfg_clear = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (hpm_we) we_cnt++;
      if (stalled) begin
        chk({tag, " stall valid"}, smp_valid, 1'b1);
        chk({tag, " stall idx"}, smp_idx, held.idx);
        chk({tag, " stall data"}, smp_data, held.data);
        chk({tag, " stall last"}, smp_last, held.last);
      end
      stalled = 1'b0;
      if (smp_valid) begin
        if (first_k < 0) first_k = k;
        if (smp_ready) begin
          r = exp_q.pop_front();
          chk({tag, " idx"}, smp_idx, r.idx);
          chk({tag, " data"}, smp_data, r.data);
          chk({tag, " last"}, smp_last, r.last);
          got++;
          last_k = k;
        end else begin
          stalled = 1'b1;
          held.idx = smp_idx; held.data = smp_data; held.last = smp_last;
        end
      end
    end
    chk({tag, " record count"}, got, n);
    chk({tag, " first valid latency"}, first_k, clr ? 3 : 2);
    if (!rdy_rand) chk({tag, " scan length"}, last_k, n * (clr ? 3 : 2));
    chk({tag, " clear writes"}, we_cnt, clr ? n : 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " idle after"}, busy, 1'b0);
    for (int i = 3; i <= 31; i++)
      chk({tag, $sformatf(" ctr%0d", i)}, ctr[i], (clr && m[i]) ? 64'd0 : snap[i]);
  endtask

  initial begin
    logic [31:3] m;
    logic [63:0] v, x;
    rec_t r;
    int first_k, got, n;
    bit done;

    rstn = 1'b0; cfg_en = 1'b0; cfg_period = '0; cfg_mask = '0; cfg_clear = 1'b0;
    trigger = 1'b0; ovr_clr = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0;
    core_wdata = '0; smp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset valid", smp_valid, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset hpm_we", hpm_we, 1'b0);
    chk("reset hpm_addr", hpm_addr, '0);
    chk("reset smp_data", smp_data, '0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int i = 3; i <= 31; i++) core_write(i, {$urandom, $urandom});

    core_write(3, 64'h10);
    core_write(5, 64'h20);
    m = '0; m[3] = 1'b1; m[5] = 1'b1;
    run_scan(m, 1'b0, 1'b0, "manual");

    core_write(4, 64'hFF);
    m = '0; m[4] = 1'b1;
    run_scan(m, 1'b1, 1'b0, "clear");

    for (int t = 0; t < 4; t++) begin
      m = 29'($urandom) & 29'($urandom);
      if (m == '0) m[$urandom_range(3, 31)] = 1'b1;
      run_scan(m, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", t));
    end

    // Core priority: three core cycles right after the trigger stall READ until t+4.
    v = {32'hC0DE_0000, $urandom};
    @(posedge clk); #1;
    cfg_mask = '0; cfg_mask[8] = 1'b1; cfg_clear = 1'b0; trigger = 1'b1; smp_ready = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = CTR_BASE + 12'd7;
    @(negedge clk);
    chk("prio rdata c1", core_rdata, ctr[10]);
    chk("prio addr c1", hpm_addr, CTR_BASE + 12'd7);
    chk("prio busy c1", busy, 1'b1);
    @(posedge clk); #1 core_addr = CTR_BASE + 12'd9;
    @(negedge clk);
    chk("prio rdata c2", core_rdata, ctr[12]);
    @(posedge clk); #1 core_we = 1'b1; core_addr = CTR_BASE + 12'd5; core_wdata = v;
    @(negedge clk);
    chk("prio we c3", hpm_we, 1'b1);
    chk("prio wdata c3", hpm_wdata, v);
    chk("prio valid c3", smp_valid, 1'b0);
    @(posedge clk); #1 core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    @(negedge clk);
    chk("prio scan addr c4", hpm_addr, CTR_BASE + 12'd5);
    chk("prio scan we c4", hpm_we, 1'b0);
    chk("prio valid c4", smp_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("prio valid c5", smp_valid, 1'b1);
    chk("prio idx c5", smp_idx, 5'd8);
    chk("prio data c5", smp_data, v);
    chk("prio last c5", smp_last, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("prio idle c6", busy, 1'b0);

    // Core write to the counter being cleared wins over the clear.
    x = {$urandom, $urandom};
    core_write(6, x);
    @(posedge clk); #1;
    cfg_mask = '0; cfg_mask[6] = 1'b1; cfg_clear = 1'b1; trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    @(negedge clk);
    chk("skip read addr", hpm_addr, CTR_BASE + 12'd3);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = CTR_BASE + 12'd3; core_wdata = 64'h55;
    @(posedge clk); #1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    @(negedge clk);
    chk("skip valid", smp_valid, 1'b1);
    chk("skip idx", smp_idx, 5'd6);
    chk("skip data", smp_data, x);
    chk("skip no scan write", hpm_we, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("skip idle", busy, 1'b0);
    chk("skip ctr6", ctr[6], 64'h55);

    // Timer scan under backpressure: period 4, then stall, overrun, drain.
    m = '0; m[$urandom_range(3, 31)] = 1'b1; m[$urandom_range(3, 31)] = 1'b1;
    build_exp(m);
    n = exp_q.size();
    @(posedge clk); #1;
    cfg_period = 32'd4; cfg_en = 1'b0; cfg_mask = m; cfg_clear = 1'b0; smp_ready = 1'b0;
    @(posedge clk); #1 cfg_en = 1'b1;
    first_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy && first_k < 0) first_k = k;
    end
    chk("timer first trigger", first_k, 4);
    r = exp_q[0];
    chk("bp valid", smp_valid, 1'b1);
    chk("bp idx", smp_idx, r.idx);
    chk("bp data", smp_data, r.data);
    chk("bp last", smp_last, r.last);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      cfg_mask = 29'($urandom);
      @(negedge clk);
      chk("bp hold valid", smp_valid, 1'b1);
      chk("bp hold idx", smp_idx, r.idx);
      chk("bp hold data", smp_data, r.data);
    end
    chk("bp overrun", overrun, 1'b1);
    @(posedge clk); #1 cfg_en = 1'b0; smp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && got < n; k++) begin
      @(negedge clk);
      if (smp_valid && smp_ready) begin
        r = exp_q.pop_front();
        chk("bp drain idx", smp_idx, r.idx);
        chk("bp drain data", smp_data, r.data);
        chk("bp drain last", smp_last, r.last);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("bp record count", got, n);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp no extra scan", busy, 1'b0);
      @(posedge clk); #1;
    end
    chk("bp overrun sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr clear", overrun, 1'b0);

    // Reset while holding a record (with overrun set).
    @(posedge clk); #1;
    cfg_mask = '0; cfg_mask[3] = 1'b1; cfg_clear = 1'b0; smp_ready = 1'b0; trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    @(negedge clk);
    chk("rst pre valid", smp_valid, 1'b1);
    chk("rst pre overrun", overrun, 1'b1);
    rstn = 1'b0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst valid", smp_valid, 1'b0);
    chk("rst idx", smp_idx, '0);
    chk("rst data", smp_data, '0);
    chk("rst last", smp_last, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst hpm_addr", hpm_addr, '0);
    chk("rst hpm_we", hpm_we, 1'b0);
    chk("rst hpm_wdata", hpm_wdata, '0);
    @(posedge clk); #1 rstn = 1'b1; smp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post rst idle", {busy, smp_valid, hpm_we}, '0);
      @(posedge clk); #1;
    end

    // Empty mask: trigger does nothing.
    cfg_mask = '0; trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("empty mask idle", {busy, smp_valid}, '0);
      @(posedge clk); #1;
    end

    // Period 1: trigger every cycle, overrun sets while scanning.
    m = '0; m[$urandom_range(3, 31)] = 1'b1;
    cfg_mask = m; cfg_period = 32'd1; cfg_en = 1'b0;
    @(posedge clk); #1 cfg_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("p1 busy", busy, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1 cfg_en = 1'b0;
    @(negedge clk);
    chk("p1 overrun", overrun, 1'b1);
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("p1 scan ends", done, 1'b1);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("p1 ovr clear", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
